// File: rtl/rx_prbs_checker_pkg.sv
// Shared PRBS9 definitions for the TX generator and the RX checker.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rx_prbs_checker_pkg;

   // PRBS9, x^9 + x^5 + 1: b[n] = b[n-5] ^ b[n-9]
   localparam int PRBS_LEN   = 9;
   localparam int PRBS_TAP_A = 9;
   localparam int PRBS_TAP_B = 5;

   // A negative sample carries a 1, zero or positive carries a 0
   localparam logic SLICE_NEG_BIT = 1'b1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10
   } chk_state_t;

   // Bit k of the state is the sequence bit emitted k+1 steps ago
   typedef logic [PRBS_LEN-1:0] prbs_state_t;

   // One QPSK symbol worth of sequence bits; I precedes Q in sequence order
   typedef struct packed {
      logic i;
      logic q;
   } sym_bits_t;

   // Next sequence bit from the last PRBS_LEN bits
   function automatic logic prbs_next_bit(input prbs_state_t s);
      return s[PRBS_TAP_B-1] ^ s[PRBS_TAP_A-1];
   endfunction

   // Hard-slice a sample given its sign bit
   function automatic logic slice_sign(input logic sign_bit);
      return (sign_bit == 1'b1) ? SLICE_NEG_BIT : ~SLICE_NEG_BIT;
   endfunction

endpackage

// File: rtl/rx_prbs_checker_prbs9_2step.sv
// PRBS9 two-bit stepper: predicts the next two sequence bits and the state after them.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register next_state.
module prbs9_2step
   import rx_prbs_checker_pkg::*;
(
   input  prbs_state_t state,
   input  logic        load,
   input  sym_bits_t   load_bits,
   output sym_bits_t   pred_bits,
   output prbs_state_t next_state
);

   logic        pred_i;
   logic        pred_q;
   prbs_state_t mid_state;

   // Predict I then Q; in load mode shift the supplied bits in instead of the predicted ones
   always_comb begin
      pred_i    = prbs_next_bit(state);
      mid_state = {state[PRBS_LEN-2:0], pred_i};
      pred_q    = prbs_next_bit(mid_state);

      pred_bits.i = pred_i;
      pred_bits.q = pred_q;

      if (load) begin
         next_state = {state[PRBS_LEN-3:0], load_bits.i, load_bits.q};
      end else begin
         next_state = {state[PRBS_LEN-3:0], pred_i, pred_q};
      end
   end

endmodule

// File: rtl/rx_prbs_checker.sv
// QPSK PRBS9 receiver: slices I/Q, self-syncs a local PRBS9 and counts bits/errors while locked.
// Latency: one cycle; state, counters and err_flag reflect a symbol the cycle after it is accepted.
// Backpressure: none; every in_valid cycle consumes one symbol, in_valid=0 freezes everything.
module rx_prbs_checker
   import rx_prbs_checker_pkg::*;
#(
   parameter int DW        = 16,
   parameter int CW        = 32,
   parameter int SEED_SYMS = 5,
   parameter int LOCK_SYMS = 16,
   parameter int WIN_SYMS  = 128,
   parameter int LOSS_THR  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] sI_in,
   input  logic signed [DW-1:0] sQ_in,
   input  logic                 clear,
   output logic                 locked,
   output logic [1:0]           state_o,
   output logic [CW-1:0]        bit_cnt,
   output logic [CW-1:0]        err_cnt,
   output logic                 err_flag
);

   localparam int SW  = $clog2(SEED_SYMS + 1);
   localparam int LW  = $clog2(LOCK_SYMS + 1);
   localparam int WW  = $clog2(WIN_SYMS + 1);
   // Window errors never exceed LOSS_THR before a symbol adds at most 2 more
   localparam int EW  = $clog2(LOSS_THR + 3);

   localparam logic [SW-1:0] SEED_LAST = SW'(SEED_SYMS - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_SYMS - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_SYMS - 1);
   localparam logic [EW-1:0] LOSS_LIM  = EW'(LOSS_THR);

   chk_state_t  state, state_nxt;
   prbs_state_t lfsr, lfsr_nxt;
   sym_bits_t   rx_bits, pred_bits;

   logic [SW-1:0] seed_cnt, seed_nxt;
   logic [LW-1:0] clean_cnt, clean_nxt;
   logic [WW-1:0] win_cnt, win_nxt;
   logic [EW-1:0] werr_cnt, werr_nxt, werr_sum;
   logic [1:0]    n_err;
   logic          flag_nxt;
   logic          cnt_en;

   logic [CW:0]   bit_sum, err_sum;
   logic [CW-1:0] bit_inc, err_inc;

   // Only the sign of each sample carries information
   logic unused_lsbs;
   assign unused_lsbs = ^{sI_in[DW-2:0], sQ_in[DW-2:0]};

   assign rx_bits.i = slice_sign(sI_in[DW-1]);
   assign rx_bits.q = slice_sign(sQ_in[DW-1]);

   // While searching, the received bits seed the LFSR; otherwise it free-runs on its own prediction
   prbs9_2step u_prbs (
      .state      (lfsr),
      .load       (state == ST_SEARCH),
      .load_bits  (rx_bits),
      .pred_bits  (pred_bits),
      .next_state (lfsr_nxt)
   );

   assign n_err    = {1'b0, pred_bits.i ^ rx_bits.i} + {1'b0, pred_bits.q ^ rx_bits.q};
   assign werr_sum = werr_cnt + EW'(n_err);

   // Saturating increments for the BER counters
   assign bit_sum = {1'b0, bit_cnt} + (CW+1)'(2);
   assign err_sum = {1'b0, err_cnt} + (CW+1)'(n_err);
   assign bit_inc = bit_sum[CW] ? {CW{1'b1}} : bit_sum[CW-1:0];
   assign err_inc = err_sum[CW] ? {CW{1'b1}} : err_sum[CW-1:0];

   // Sync FSM: next state, phase counters and error pulse for the accepted symbol
   always_comb begin
      state_nxt = state;
      seed_nxt  = seed_cnt;
      clean_nxt = clean_cnt;
      win_nxt   = win_cnt;
      werr_nxt  = werr_cnt;
      flag_nxt  = 1'b0;
      cnt_en    = 1'b0;

      if (in_valid) begin
         case (state)
            ST_SEARCH: begin
               if (seed_cnt == SEED_LAST) begin
                  state_nxt = ST_VERIFY;
                  seed_nxt  = '0;
                  clean_nxt = '0;
               end else begin
                  seed_nxt = seed_cnt + SW'(1);
               end
            end
            ST_VERIFY: begin
               if (n_err != 2'd0) begin
                  flag_nxt  = 1'b1;
                  state_nxt = ST_SEARCH;
                  seed_nxt  = '0;
               end else if (clean_cnt == LOCK_LAST) begin
                  state_nxt = ST_LOCKED;
                  win_nxt   = '0;
                  werr_nxt  = '0;
               end else begin
                  clean_nxt = clean_cnt + LW'(1);
               end
            end
            ST_LOCKED: begin
               cnt_en   = 1'b1;
               flag_nxt = (n_err != 2'd0);
               if (werr_sum > LOSS_LIM) begin
                  state_nxt = ST_SEARCH;
                  seed_nxt  = '0;
               end else if (win_cnt == WIN_LAST) begin
                  win_nxt  = '0;
                  werr_nxt = '0;
               end else begin
                  win_nxt  = win_cnt + WW'(1);
                  werr_nxt = werr_sum;
               end
            end
            default: begin
               state_nxt = ST_SEARCH;
               seed_nxt  = '0;
            end
         endcase
      end
   end

   // State, phase counters, LFSR and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_SEARCH;
         lfsr      <= '0;
         seed_cnt  <= '0;
         clean_cnt <= '0;
         win_cnt   <= '0;
         werr_cnt  <= '0;
         locked    <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         state     <= state_nxt;
         seed_cnt  <= seed_nxt;
         clean_cnt <= clean_nxt;
         win_cnt   <= win_nxt;
         werr_cnt  <= werr_nxt;
         locked    <= (state_nxt == ST_LOCKED);
         err_flag  <= flag_nxt;
         if (in_valid) begin
            lfsr <= lfsr_nxt;
         end
      end
   end

   // BER counters: clear has priority over a counting symbol, values hold across lock loss
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt <= '0;
         err_cnt <= '0;
      end else if (clear) begin
         bit_cnt <= '0;
         err_cnt <= '0;
      end else if (cnt_en) begin
         bit_cnt <= bit_inc;
         err_cnt <= err_inc;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Randomized scoreboard bench for rx_prbs_checker with a sequence-level reference model.
// Latency: expects each cycle's outputs one clock after the inputs are driven.
// Backpressure: n/a.
module tb_rx_prbs_checker;

   localparam int DW        = 16;
   localparam int SEED_SYMS = 5;
   localparam int LOCK_SYMS = 16;
   localparam int WIN_SYMS  = 128;
   localparam int LOSS_THR  = 32;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 in_valid;
   logic signed [DW-1:0] sI_in, sQ_in;
   logic                 clear;
   logic                 locked, locked4;
   logic [1:0]           state_o, state4;
   logic [31:0]          bit_cnt, err_cnt;
   logic [3:0]           bit4, err4;
   logic                 err_flag, flag4;

   always #5 clk = ~clk;

   rx_prbs_checker #(.DW(DW), .CW(32), .SEED_SYMS(SEED_SYMS), .LOCK_SYMS(LOCK_SYMS),
                     .WIN_SYMS(WIN_SYMS), .LOSS_THR(LOSS_THR)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .sI_in(sI_in), .sQ_in(sQ_in),
      .clear(clear), .locked(locked), .state_o(state_o), .bit_cnt(bit_cnt),
      .err_cnt(err_cnt), .err_flag(err_flag));

   rx_prbs_checker #(.DW(DW), .CW(4), .SEED_SYMS(SEED_SYMS), .LOCK_SYMS(LOCK_SYMS),
                     .WIN_SYMS(WIN_SYMS), .LOSS_THR(LOSS_THR)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .sI_in(sI_in), .sQ_in(sQ_in),
      .clear(clear), .locked(locked4), .state_o(state4), .bit_cnt(bit4),
      .err_cnt(err4), .err_flag(flag4));

   typedef struct {
      int          st;
      bit          lk;
      logic [31:0] bc;
      logic [31:0] ec;
      bit          ef;
      logic [3:0]  bc4;
      logic [3:0]  ec4;
   } exp_t;

   exp_t exp_q[$];
   bit   armed = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   gap_mode = 0;

   // Reference model: sequence history as a bit queue, phases tracked as plain counts
   bit     hist[$];
   bit     tx[$];
   int     m_st, m_seed, m_clean, m_win, m_werr;
   longint m_bc, m_ec, m_bc4, m_ec4;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int k = 0; k < 9; k++) hist.push_back(1'b0);
      m_st = 0; m_seed = 0; m_clean = 0; m_win = 0; m_werr = 0;
      m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
   endfunction

   function automatic bit model_pred();
      bit b;
      b = hist[$-4] ^ hist[$-8];
      hist.push_back(b);
      void'(hist.pop_front());
      return b;
   endfunction

   function automatic longint sat(input longint v, input longint lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic void model_step(input bit v, input bit ri, input bit rq, input bit clr,
                                      output exp_t e);
      bit pi, pq, cnt;
      int nerr;
      e.ef = 1'b0;
      cnt  = 1'b0;
      nerr = 0;
      if (v) begin
         if (m_st == 0) begin
            hist.push_back(ri); void'(hist.pop_front());
            hist.push_back(rq); void'(hist.pop_front());
            m_seed++;
            if (m_seed == SEED_SYMS) begin m_st = 1; m_clean = 0; end
         end else begin
            pi = model_pred();
            pq = model_pred();
            nerr = int'(pi != ri) + int'(pq != rq);
            if (m_st == 1) begin
               if (nerr != 0) begin
                  e.ef = 1'b1; m_st = 0; m_seed = 0;
               end else begin
                  m_clean++;
                  if (m_clean == LOCK_SYMS) begin m_st = 2; m_win = 0; m_werr = 0; end
               end
            end else begin
               cnt  = 1'b1;
               e.ef = (nerr != 0);
               m_werr += nerr;
               m_win++;
               if (m_werr > LOSS_THR) begin
                  m_st = 0; m_seed = 0;
               end else if (m_win == WIN_SYMS) begin
                  m_win = 0; m_werr = 0;
               end
            end
         end
      end
      if (clr) begin
         m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
      end else if (cnt) begin
         m_bc  = sat(m_bc + 2, 64'hFFFF_FFFF);
         m_ec  = sat(m_ec + nerr, 64'hFFFF_FFFF);
         m_bc4 = sat(m_bc4 + 2, 15);
         m_ec4 = sat(m_ec4 + nerr, 15);
      end
      e.st  = m_st;
      e.lk  = (m_st == 2);
      e.bc  = m_bc[31:0];
      e.ec  = m_ec[31:0];
      e.bc4 = m_bc4[3:0];
      e.ec4 = m_ec4[3:0];
   endfunction

   // Reference PRBS9 transmitter seeded with all ones
   function automatic bit gen_bit();
      bit b;
      b = tx[$-4] ^ tx[$-8];
      tx.push_back(b);
      void'(tx.pop_front());
      return b;
   endfunction

   function automatic logic signed [DW-1:0] mk_sample(input bit b);
      int v;
      if (b) v = -(1 + int'($urandom_range(0, 32767)));
      else if ($urandom_range(0, 3) == 0) v = 0;
      else v = int'($urandom_range(0, 32767));
      return DW'(v);
   endfunction

   task automatic cycle(input bit v, input logic signed [DW-1:0] si, input logic signed [DW-1:0] sq,
                        input bit clr);
      exp_t e;
      in_valid = v; sI_in = si; sQ_in = sq; clear = clr;
      model_step(v, si < 0, sq < 0, clr, e);
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic send_sym(input bit fi, input bit fq, input bit clr);
      bit bi, bq;
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
         cycle(1'b0, mk_sample(1'($urandom_range(0, 1))), mk_sample(1'($urandom_range(0, 1))), 1'b0);
      bi = gen_bit() ^ fi;
      bq = gen_bit() ^ fq;
      cycle(1'b1, mk_sample(bi), mk_sample(bq), clr);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_locked"},  locked,   0);
      check({tag, "_state"},   state_o,  0);
      check({tag, "_bit_cnt"}, bit_cnt,  0);
      check({tag, "_err_cnt"}, err_cnt,  0);
      check({tag, "_err_flag"}, err_flag, 0);
      check({tag, "_bit4"},    bit4,     0);
   endtask

   // Arm the monitor for the expectation whose inputs this edge just consumed
   always @(posedge clk) armed = (exp_q.size() != 0);

   // Monitor: pop and compare away from the active edge
   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         armed = 1'b0;
         e = exp_q.pop_front();
         check("sb_state",    state_o,  e.st);
         check("sb_locked",   locked,   e.lk);
         check("sb_bit_cnt",  bit_cnt,  e.bc);
         check("sb_err_cnt",  err_cnt,  e.ec);
         check("sb_err_flag", err_flag, e.ef);
         check("sb_state4",   state4,   e.st);
         check("sb_locked4",  locked4,  e.lk);
         check("sb_flag4",    flag4,    e.ef);
         check("sb_bit4",     bit4,     e.bc4);
         check("sb_err4",     err4,     e.ec4);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 0; sI_in = 0; sQ_in = 0; clear = 0;
      model_reset();
      for (int k = 0; k < 9; k++) tx.push_back(1'b1);

      // Reset held for 100 ns, then 10 idle cycles
      #95;
      check_zero("reset");
      #5 reset = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++)
         cycle(1'b0, mk_sample(1'($urandom_range(0, 1))), mk_sample(1'($urandom_range(0, 1))), 1'b0);
      check_zero("idle");

      // Clean stream with in_valid every other cycle
      gap_mode = 1;
      for (int k = 0; k < 4; k++) send_sym(0, 0, 0);
      check("search_sym4", state_o, 0);
      send_sym(0, 0, 0);
      check("verify_sym5", state_o, 1);
      for (int k = 0; k < 15; k++) send_sym(0, 0, 0);
      check("unlocked_sym20", locked, 0);
      send_sym(0, 0, 0);
      check("locked_sym21", locked, 1);
      check("state_sym21", state_o, 2);
      for (int k = 0; k < 100; k++) send_sym(0, 0, 0);
      check("clean_bit_cnt", bit_cnt, 200);
      check("clean_err_cnt", err_cnt, 0);
      check("sat_bit4", bit4, 15);

      // Single Q error while locked
      gap_mode = 2;
      send_sym(0, 1, 0);
      check("single_err_flag", err_flag, 1);
      check("single_err_cnt", err_cnt, 1);
      check("single_locked", locked, 1);
      check("single_bit_cnt", bit_cnt, 202);
      cycle(1'b0, 0, 0, 1'b0);
      check("single_flag_drop", err_flag, 0);

      // Finish the first lock window, then clear while locked
      for (int k = 0; k < 27; k++) send_sym(0, 0, 0);
      cycle(1'b0, 0, 0, 1'b1);
      check("clear_bit_cnt", bit_cnt, 0);
      check("clear_err_cnt", err_cnt, 0);
      check("clear_locked", locked, 1);

      // Burst of I errors in a fresh window: lock lost on the 33rd
      for (int k = 0; k < 32; k++) send_sym(1, 0, 0);
      check("burst32_state", state_o, 2);
      send_sym(1, 0, 0);
      check("loss_state", state_o, 0);
      check("loss_err_cnt", err_cnt, 33);
      check("loss_bit_cnt", bit_cnt, 66);
      for (int k = 0; k < 7; k++) send_sym(1, 0, 0);
      for (int k = 0; k < 80; k++) send_sym(0, 0, 0);
      check("relock", locked, 1);
      check("hold_err_cnt", err_cnt, 33);

      // Clear coinciding with a counting symbol
      send_sym(0, 0, 1);
      check("clear_wins_bit", bit_cnt, 0);
      check("clear_wins_err", err_cnt, 0);

      // Asynchronous reset while a symbol is being presented
      send_sym(0, 0, 0);
      @(negedge clk); #1;
      in_valid = 1'b1;
      reset = 1'b0;
      exp_q.delete();
      armed = 1'b0;
      #1;
      check_zero("async_reset");
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;

      // Error on the 8th VERIFY symbol
      for (int k = 0; k < 5; k++) send_sym(0, 0, 0);
      check("vfail_verify", state_o, 1);
      for (int k = 0; k < 7; k++) send_sym(0, 0, 0);
      check("vfail_still_verify", state_o, 1);
      send_sym(1, 0, 0);
      check("vfail_state", state_o, 0);
      check("vfail_flag", err_flag, 1);
      for (int k = 0; k < 20; k++) send_sym(0, 0, 0);
      check("vfail_nolock20", locked, 0);
      send_sym(0, 0, 0);
      check("vfail_lock21", locked, 1);

      // Random errors and clears, light then heavy
      for (int k = 0; k < 600; k++)
         send_sym($urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0);
      for (int k = 0; k < 80; k++)
         send_sym($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 0);
      for (int k = 0; k < 200; k++)
         send_sym($urandom_range(0, 199) == 0, 0, 0);

      cycle(1'b0, 0, 0, 1'b0);
      @(negedge clk); #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
